// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter slice.
package rf_write_arbiter_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_ADD_WIDTH = 5;
  localparam int ZERO_REG          = 0;

  typedef struct packed {
    logic [DEFAULT_ADD_WIDTH-1:0] addr;
    logic [DEFAULT_WIDTH-1:0]     data;
  } wr_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_winner,
  output logic               o_any
);

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_grant[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
        o_winner = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbitration of NUM_REQ one-entry write buffers onto a single register-file write port.
// Optional RF_WRITE_ARB_STATS_EN adds saturating stall and conflict counters.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADD_WIDTH = DEFAULT_ADD_WIDTH,
  parameter int NUM_REQ   = 3
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_REQ-1:0]           REQ_VALID,
  input  logic [NUM_REQ*ADD_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*WIDTH-1:0]     REQ_DATA,
  output logic [NUM_REQ-1:0]           REQ_READY,
  input  logic                         FLUSH,
  input  logic [ADD_WIDTH-1:0]         QUERY_ADDR_1,
  input  logic [ADD_WIDTH-1:0]         QUERY_ADDR_2,
  output logic                         QUERY_HIT_1,
  output logic                         QUERY_HIT_2,
  output logic                         RF_WRITE_ENABLE,
  output logic [ADD_WIDTH-1:0]         RF_ADDRESS,
  output logic [WIDTH-1:0]             RF_WRITE_DATA
`ifdef RF_WRITE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        STALL_COUNT,
  output logic [15:0]                  CONFLICT_COUNT
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   r_full;
  logic [ADD_WIDTH-1:0] r_addr [NUM_REQ];
  logic [WIDTH-1:0]     r_data [NUM_REQ];
  logic [PTR_W-1:0]     r_ptr;
  logic                 r_rf_we;
  logic [ADD_WIDTH-1:0] r_rf_addr;
  logic [WIDTH-1:0]     r_rf_data;

  logic [NUM_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]     w_winner;
  logic                 w_any;
  logic [NUM_REQ-1:0]   w_accept;
  logic [PTR_W-1:0]     w_ptr_next;
  logic [ADD_WIDTH-1:0] w_win_addr;
  logic [WIDTH-1:0]     w_win_data;
  logic                 w_hit_1;
  logic                 w_hit_2;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .i_req   (r_full),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_winner(w_winner),
    .o_any   (w_any)
  );

  // A granted buffer can take a new entry in the same cycle it drains.
  assign REQ_READY  = ~r_full | w_grant;
  assign w_accept   = REQ_VALID & REQ_READY;
  assign w_ptr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);

  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_addr = r_addr[i];
        w_win_data = r_data[i];
      end
    end
  end

  always_comb begin
    w_hit_1 = 1'b0;
    w_hit_2 = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_full[i] && (r_addr[i] == QUERY_ADDR_1)) w_hit_1 = 1'b1;
      if (r_full[i] && (r_addr[i] == QUERY_ADDR_2)) w_hit_2 = 1'b1;
    end
    if (r_rf_we && (r_rf_addr == QUERY_ADDR_1)) w_hit_1 = 1'b1;
    if (r_rf_we && (r_rf_addr == QUERY_ADDR_2)) w_hit_2 = 1'b1;
    if (QUERY_ADDR_1 == ADD_WIDTH'(ZERO_REG)) w_hit_1 = 1'b0;
    if (QUERY_ADDR_2 == ADD_WIDTH'(ZERO_REG)) w_hit_2 = 1'b0;
  end

  assign QUERY_HIT_1 = w_hit_1;
  assign QUERY_HIT_2 = w_hit_2;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_full    <= '0;
      r_ptr     <= '0;
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (FLUSH) begin
      r_full  <= '0;
      r_rf_we <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_full[i] <= 1'b1;
          r_addr[i] <= REQ_ADDR[i*ADD_WIDTH +: ADD_WIDTH];
          r_data[i] <= REQ_DATA[i*WIDTH +: WIDTH];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
      // Writes to the zero register are consumed but never reach the port.
      if (w_any) begin
        r_ptr     <= w_ptr_next;
        r_rf_we   <= (w_win_addr != ADD_WIDTH'(ZERO_REG));
        r_rf_addr <= w_win_addr;
        r_rf_data <= w_win_data;
      end else begin
        r_rf_we <= 1'b0;
      end
    end
  end

  assign RF_WRITE_ENABLE = r_rf_we;
  assign RF_ADDRESS      = r_rf_addr;
  assign RF_WRITE_DATA   = r_rf_data;

`ifdef RF_WRITE_ARB_STATS_EN
  logic [15:0] r_stall [NUM_REQ];
  logic [15:0] r_conflict;
  int          w_full_cnt;

  always_comb begin
    w_full_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) w_full_cnt = w_full_cnt + int'(r_full[i]);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_conflict <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_stall[i] <= '0;
    end else begin
      if (w_full_cnt >= 2) r_conflict <= sat_inc16(r_conflict);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (REQ_VALID[i] && !REQ_READY[i]) r_stall[i] <= sat_inc16(r_stall[i]);
      end
    end
  end

  always_comb begin
    STALL_COUNT = '0;
    for (int i = 0; i < NUM_REQ; i++) STALL_COUNT[i*16 +: 16] = r_stall[i];
  end
  assign CONFLICT_COUNT = r_conflict;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int W = 32;
  localparam int A = 5;
  localparam int N = 3;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             RESET;
  logic [N-1:0]     REQ_VALID;
  logic [N*A-1:0]   REQ_ADDR;
  logic [N*W-1:0]   REQ_DATA;
  logic [N-1:0]     REQ_READY;
  logic             FLUSH;
  logic [A-1:0]     QUERY_ADDR_1, QUERY_ADDR_2;
  logic             QUERY_HIT_1, QUERY_HIT_2;
  logic             RF_WRITE_ENABLE;
  logic [A-1:0]     RF_ADDRESS;
  logic [W-1:0]     RF_WRITE_DATA;
`ifdef RF_WRITE_ARB_STATS_EN
  logic [N*16-1:0]  stall_count;
  logic [15:0]      conflict_count;
`endif

  rf_write_arbiter #(.WIDTH(W), .ADD_WIDTH(A), .NUM_REQ(N)) dut (
    .CLK            (clk),
    .RESET          (RESET),
    .REQ_VALID      (REQ_VALID),
    .REQ_ADDR       (REQ_ADDR),
    .REQ_DATA       (REQ_DATA),
    .REQ_READY      (REQ_READY),
    .FLUSH          (FLUSH),
    .QUERY_ADDR_1   (QUERY_ADDR_1),
    .QUERY_ADDR_2   (QUERY_ADDR_2),
    .QUERY_HIT_1    (QUERY_HIT_1),
    .QUERY_HIT_2    (QUERY_HIT_2),
    .RF_WRITE_ENABLE(RF_WRITE_ENABLE),
    .RF_ADDRESS     (RF_ADDRESS),
    .RF_WRITE_DATA  (RF_WRITE_DATA)
`ifdef RF_WRITE_ARB_STATS_EN
    ,
    .STALL_COUNT    (stall_count),
    .CONFLICT_COUNT (conflict_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Scoreboard: expected {addr,data} of every write-port assertion, in order
  logic [A+W-1:0] exp_q[$];

  // Reference model: pending writes per source, rotating priority, last port value
  bit           m_full [N];
  logic [A-1:0] m_addr [N];
  logic [W-1:0] m_data [N];
  int           m_ptr;
  bit           m_we;
  logic [A-1:0] m_oaddr;
  logic [W-1:0] m_odata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_ptr   = 0;
    m_we    = 1'b0;
    m_oaddr = '0;
    m_odata = '0;
  endtask

  function automatic bit m_hit(input logic [A-1:0] q);
    if (q == 0) return 1'b0;
    for (int i = 0; i < N; i++) if (m_full[i] && m_addr[i] == q) return 1'b1;
    if (m_we && m_oaddr == q) return 1'b1;
    return 1'b0;
  endfunction

  // Driver: one cycle of stimulus, checks of pre-edge outputs, then model advance
  task automatic cycle(input logic [N-1:0] v, input logic [N*A-1:0] a, input logic [N*W-1:0] d,
                       input logic fl, input logic rs, input logic [A-1:0] q1, input logic [A-1:0] q2);
    int win;
    logic [N-1:0] rdy;
    @(negedge clk);
    REQ_VALID = v; REQ_ADDR = a; REQ_DATA = d; FLUSH = fl; RESET = rs;
    QUERY_ADDR_1 = q1; QUERY_ADDR_2 = q2;
    #1;
    win = -1;
    for (int k = 0; k < N; k++) if (win < 0 && m_full[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) rdy[i] = !m_full[i] || (i == win);
    chk("req_ready", 64'(REQ_READY), 64'(rdy));
    chk("rf_we",     64'(RF_WRITE_ENABLE), 64'(m_we));
    chk("rf_addr",   64'(RF_ADDRESS), 64'(m_oaddr));
    chk("rf_data",   64'(RF_WRITE_DATA), 64'(m_odata));
    chk("query_hit_1", 64'(QUERY_HIT_1), 64'(m_hit(q1)));
    chk("query_hit_2", 64'(QUERY_HIT_2), 64'(m_hit(q2)));
    if (!rs) begin
      model_reset();
    end else if (fl) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_we = 1'b0;
    end else begin
      if (win >= 0) begin
        m_we    = (m_addr[win] != 0);
        m_oaddr = m_addr[win];
        m_odata = m_data[win];
        if (m_we) exp_q.push_back({m_addr[win], m_data[win]});
        m_full[win] = 1'b0;
        m_ptr = (win + 1) % N;
      end else begin
        m_we = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && rdy[i]) begin
          m_full[i] = 1'b1;
          m_addr[i] = a[i*A +: A];
          m_data[i] = d[i*W +: W];
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic [A-1:0] q1, input logic [A-1:0] q2);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0, 1'b1, q1, q2);
  endtask

  // Monitor: every write-port assertion must match the oldest expected write
  logic [A+W-1:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && RF_WRITE_ENABLE === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rf_write_unexpected actual=%0h/%0h expected=none", RF_ADDRESS, RF_WRITE_DATA);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("rf_write", 64'({RF_ADDRESS, RF_WRITE_DATA}), 64'(mon_exp));
        end
      end
    end
  end

  initial begin
    RESET = 1'b0; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0; FLUSH = 1'b0;
    QUERY_ADDR_1 = '0; QUERY_ADDR_2 = '0;
    repeat (2) @(posedge clk);
    model_reset();
    mon_en = 1'b1;
    cycle('0, '0, '0, 1'b0, 1'b0, 5'd0, 5'd0);

    // Reset in the middle of a stream from requester 0
    cycle(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h11}, 1'b0, 1'b1, 5'd5, 5'd0);
    cycle(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h22}, 1'b0, 1'b0, 5'd5, 5'd0);
    idle(3, 5'd5, 5'd0);

    // All three requesters together, pointer at 0
    cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 1'b1, 5'd2, 5'd3);
    idle(5, 5'd2, 5'd3);

    // Move pointer to 2, then same-address conflict between requesters 1 and 2
    cycle(3'b001, {5'd0, 5'd0, 5'd1}, {32'h0, 32'h0, 32'h1}, 1'b0, 1'b1, 5'd1, 5'd0);
    idle(2, 5'd1, 5'd0);
    cycle(3'b010, {5'd0, 5'd2, 5'd0}, {32'h0, 32'h2, 32'h0}, 1'b0, 1'b1, 5'd2, 5'd0);
    idle(2, 5'd2, 5'd0);
    cycle(3'b110, {5'd7, 5'd7, 5'd0}, {32'h6666, 32'h5555, 32'h0}, 1'b0, 1'b1, 5'd7, 5'd0);
    idle(4, 5'd7, 5'd0);

    // Zero-register write is swallowed
    cycle(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hDEAD}, 1'b0, 1'b1, 5'd0, 5'd0);
    idle(3, 5'd0, 5'd0);

    // Flush with buffers holding addrs 4 and 9
    cycle(3'b011, {5'd0, 5'd9, 5'd4}, {32'h0, 32'h99, 32'h44}, 1'b0, 1'b1, 5'd4, 5'd9);
    cycle('0, '0, '0, 1'b1, 1'b1, 5'd4, 5'd9);
    idle(3, 5'd4, 5'd9);

    // Read-after-write hazard on addr 12
    cycle(3'b001, {5'd0, 5'd0, 5'd12}, {32'h0, 32'h0, 32'hC0DE}, 1'b0, 1'b1, 5'd12, 5'd13);
    idle(4, 5'd12, 5'd13);

    // Random traffic over a small address range to provoke conflicts
    for (int n = 0; n < 500; n++) begin
      logic [N*A-1:0] ra;
      logic [N*W-1:0] rd;
      for (int i = 0; i < N; i++) begin
        ra[i*A +: A] = A'($urandom_range(0, 7));
        rd[i*W +: W] = $urandom;
      end
      cycle(N'($urandom_range(0, (1 << N) - 1)), ra, rd,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0),
            A'($urandom_range(0, 7)), A'($urandom_range(0, 7)));
    end
    idle(6, 5'd0, 5'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback sources (e.g. ALU, load unit, mul/div).
- Each source has a one-entry holding buffer behind a valid/ready handshake. A round-robin arbiter drains the buffers into a registered write port that drives the register file directly.
- Reports pending-write hits for two read addresses so decode can stall on outstanding writes.

Parameters:
- WIDTH, 32, data width of a write.
- ADD_WIDTH, 5, register address width.
- NUM_REQ, 3, number of write requesters (2..8).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  reset, synchronous and active-low.
- REQ_VALID  in  NUM_REQ  per-requester write request.
- REQ_ADDR  in  NUM_REQ*ADD_WIDTH  packed destination addresses, requester i at bits [i*ADD_WIDTH +: ADD_WIDTH].
- REQ_DATA  in  NUM_REQ*WIDTH  packed write data, same packing.
- REQ_READY  out  NUM_REQ  per-requester accept; depends on registered state only.
- FLUSH  in  1  drop all buffered, not-yet-granted writes.
- QUERY_ADDR_1  in  ADD_WIDTH  read address to check.
- QUERY_ADDR_2  in  ADD_WIDTH  read address to check.
- QUERY_HIT_1  out  1  a pending write targets QUERY_ADDR_1.
- QUERY_HIT_2  out  1  a pending write targets QUERY_ADDR_2.
- RF_WRITE_ENABLE  out  1  register-file write enable (registered).
- RF_ADDRESS  out  ADD_WIDTH  register-file write address (registered).
- RF_WRITE_DATA  out  WIDTH  register-file write data (registered).

Behaviour:
- Reset (RESET=0 at an edge):
  - all buffers empty; round-robin pointer = 0.
  - RF_WRITE_ENABLE=0, RF_ADDRESS=0, RF_WRITE_DATA=0.
  - Reset overrides every other input, including mid-burst; in-flight buffered writes are lost.
- Buffer i holds {full, addr, data}.
- Grant:
  - grant_i is computed combinationally from the registered full flags and the pointer.
  - Winner is the first full buffer searching from the pointer upward, wrapping at NUM_REQ.
  - At most one grant per cycle.
- REQ_READY[i] = ~full_i | grant_i. A sole requester streams at 1 write/cycle.
- Accept at VALID&READY: buffer i loads addr/data and is full next cycle. A grant in the same cycle empties the old entry, and the load wins.
- Pointer: on any grant, pointer <= winner+1 modulo NUM_REQ; no grant leaves it unchanged.
- Output stage, every cycle:
  - RF_WRITE_ENABLE <= any grant AND winner addr != 0.
  - RF_ADDRESS / RF_WRITE_DATA <= winner entry when granted, else hold their values.
  - Writes to address 0 are accepted, granted, consumed and never asserted on the write port.
- Latency: accepted at edge t, earliest write-port assertion is in the cycle after edge t+1; the register file captures it at edge t+2.
- Ordering:
  - Writes from one requester commit in acceptance order.
  - Writes from different requesters to the same address commit in grant order; the last granted value persists.
- FLUSH: at the edge, all full flags clear and no grant takes effect (output enable <= 0). The output stage already asserted this cycle still commits. Accepts in the FLUSH cycle are dropped.
- QUERY_HIT_n is combinational. It is 1 iff QUERY_ADDR_n != 0 and matches a full buffer's addr or the output stage while RF_WRITE_ENABLE=1.

Optional Feature:
- Macro RF_WRITE_ARB_STATS_EN.
- Defined:
  - adds outputs STALL_COUNT (NUM_REQ*16) and CONFLICT_COUNT (16).
  - STALL_COUNT[i] increments every cycle REQ_VALID[i]&~REQ_READY[i].
  - CONFLICT_COUNT increments every cycle with 2 or more full buffers.
  - Counters saturate at 0xFFFF and clear on reset only.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package: default WIDTH/ADD_WIDTH constants, the write-request struct {addr, data}, and the zero-register address constant.
- One sub-module, rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant and winner index out, purely combinational. Reusable for other shared resources.

Test Plan:
- Reset mid-stream:
  - Stimulus: requester 0 streams addr 5 data 0x11 then 0x22; RESET=0 on the second cycle.
  - Response: no write port activity; outputs 0; REQ_READY=all 1 after release.
- Round-robin:
  - Stimulus: three requesters valid together to addrs 1,2,3 with data 0xA,0xB,0xC, pointer 0.
  - Response: write port shows (1,0xA),(2,0xB),(3,0xC) on consecutive cycles; REQ_READY[1]=0 for one cycle.
- Same-address conflict:
  - Stimulus: req1 writes addr 7=0x5555 and req2 writes addr 7=0x6666 in the same cycle, pointer 2.
  - Response: 0x6666 written first, then 0x5555.
- x0 drop:
  - Stimulus: write addr 0 data 0xDEAD.
  - Response: REQ_READY accepts, RF_WRITE_ENABLE never 1, QUERY_HIT for addr 0 stays 0.
- FLUSH:
  - Stimulus: buffers full at addrs 4,9; FLUSH=1.
  - Response: next cycle no enable, QUERY_HIT on 4 and 9 = 0, all REQ_READY=1.
- Query hazard:
  - Stimulus: accept addr 12; QUERY_ADDR_1=12.
  - Response: QUERY_HIT_1=1 from the edge after acceptance through the write-port cycle, 0 afterwards.
